// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the control bundle carried from ID into EX.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 16;
    localparam int SHAM_W = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'd0,
        REGDST_RD   = 2'd1,
        REGDST_RA   = 2'd2,
        REGDST_NONE = 2'd3
    } regdst_t;

    localparam regbits_t REG_RA = 5'd31;

    typedef struct packed {
        aluop_t     aluop;
        logic       mem_to_reg;
        logic       reg_wen;
        logic       dwen;
        logic       dren;
        logic       halt;
        regdst_t    reg_dst;
        logic [2:0] pc_src;
        logic [2:0] alu_src;
    } ctrl_bundle_t;

    // Whole EX slot as one vector: a bubble is simply '0.
    typedef struct packed {
        logic              valid;
        ctrl_bundle_t      ctrl;
        regbits_t          rs;
        regbits_t          rt;
        regbits_t          rd;
        regbits_t          wsel;
        logic [IMM_W-1:0]  imm;
        logic [SHAM_W-1:0] shamt;
        word_t             pc4;
        word_t             rdat1;
        word_t             rdat2;
    } ex_bundle_t;

    function automatic regbits_t resolve_wsel(regdst_t dst, regbits_t rt, regbits_t rd);
        case (dst)
            REGDST_RT: return rt;
            REGDST_RD: return rd;
            REGDST_RA: return REG_RA;
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_hazard_latch_if.sv
// ID/EX boundary signals: decoded bundle in, registered bundle and stall out.
interface id_ex_hazard_latch_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              id_valid;
    regbits_t          id_rs, id_rt, id_rd;
    aluop_t            id_aluop;
    logic [IMM_W-1:0]  id_imm;
    logic [SHAM_W-1:0] id_shamt;
    logic              id_MemToReg, id_RegWEN, id_dWEN, id_dREN, id_halt;
    logic [1:0]        id_RegDst;
    logic [2:0]        id_PCSrc, id_ALUSrc;
    word_t             id_pc4, id_rdat1, id_rdat2;
    logic              ex_ready;
    logic              flush;

    logic              id_stall;
    logic              ex_valid;
    regbits_t          ex_rs, ex_rt, ex_rd, ex_wsel;
    aluop_t            ex_aluop;
    logic [IMM_W-1:0]  ex_imm;
    logic [SHAM_W-1:0] ex_shamt;
    logic              ex_MemToReg, ex_RegWEN, ex_dWEN, ex_dREN, ex_halt;
    logic [1:0]        ex_RegDst;
    logic [2:0]        ex_PCSrc, ex_ALUSrc;
    word_t             ex_pc4, ex_rdat1, ex_rdat2;
    logic              halted;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_aluop, id_imm, id_shamt,
               id_MemToReg, id_RegWEN, id_dWEN, id_dREN, id_halt, id_RegDst,
               id_PCSrc, id_ALUSrc, id_pc4, id_rdat1, id_rdat2, ex_ready, flush,
        input  id_stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_wsel, ex_aluop, ex_imm,
               ex_shamt, ex_MemToReg, ex_RegWEN, ex_dWEN, ex_dREN, ex_halt,
               ex_RegDst, ex_PCSrc, ex_ALUSrc, ex_pc4, ex_rdat1, ex_rdat2,
               halted, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_aluop, id_imm, id_shamt,
               id_MemToReg, id_RegWEN, id_dWEN, id_dREN, id_halt, id_RegDst,
               id_PCSrc, id_ALUSrc, id_pc4, id_rdat1, id_rdat2, ex_ready, flush,
        output id_stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_wsel, ex_aluop, ex_imm,
               ex_shamt, ex_MemToReg, ex_RegWEN, ex_dWEN, ex_dREN, ex_halt,
               ex_RegDst, ex_PCSrc, ex_ALUSrc, ex_pc4, ex_rdat1, ex_rdat2,
               halted, bubble_cnt
    );

endinterface

// File: rtl/id_ex_hazard_latch_hazard_detect.sv
// Load-use compare between the load sitting in EX and the operands read in ID.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_dren_i,
    input  regbits_t   ex_wsel_i,
    input  logic       id_valid_i,
    input  regbits_t   id_rs_i,
    input  regbits_t   id_rt_i,
    input  logic [2:0] id_alusrc_i,
    input  logic       id_dwen_i,
    output logic       hazard_o
);
    logic rs_hit, rt_hit;

    assign rs_hit = (ex_wsel_i == id_rs_i);
    // rt is a real source only as ALU operand B or as store data.
    assign rt_hit = (ex_wsel_i == id_rt_i) && ((id_alusrc_i == 3'd0) || id_dwen_i);

    assign hazard_o = ex_valid_i && ex_dren_i && (ex_wsel_i != '0) && id_valid_i
                      && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_hazard_latch.sv
// ID/EX pipeline register: capture, hold on EX stall, or bubble for halt,
// flush (deferred across stalls) and load-use hazards.
module id_ex_hazard_latch
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic                 CLK,
    input logic                 RST,
    id_ex_hazard_latch_if.slave bus
);
    ex_bundle_t       ex_q, ex_d, id_bundle;
    logic             flush_pending_q, flush_pending_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             hazard, count_bubble;

    hazard_detect u_hazard_detect (
        .ex_valid_i  (ex_q.valid),
        .ex_dren_i   (ex_q.ctrl.dren),
        .ex_wsel_i   (ex_q.wsel),
        .id_valid_i  (bus.id_valid),
        .id_rs_i     (bus.id_rs),
        .id_rt_i     (bus.id_rt),
        .id_alusrc_i (bus.id_ALUSrc),
        .id_dwen_i   (bus.id_dWEN),
        .hazard_o    (hazard)
    );

    always_comb begin
        id_bundle.valid           = bus.id_valid;
        id_bundle.ctrl.aluop      = bus.id_aluop;
        id_bundle.ctrl.mem_to_reg = bus.id_MemToReg;
        id_bundle.ctrl.reg_wen    = bus.id_RegWEN;
        id_bundle.ctrl.dwen       = bus.id_dWEN;
        id_bundle.ctrl.dren       = bus.id_dREN;
        id_bundle.ctrl.halt       = bus.id_halt;
        id_bundle.ctrl.reg_dst    = regdst_t'(bus.id_RegDst);
        id_bundle.ctrl.pc_src     = bus.id_PCSrc;
        id_bundle.ctrl.alu_src    = bus.id_ALUSrc;
        id_bundle.rs              = bus.id_rs;
        id_bundle.rt              = bus.id_rt;
        id_bundle.rd              = bus.id_rd;
        id_bundle.wsel            = resolve_wsel(regdst_t'(bus.id_RegDst), bus.id_rt, bus.id_rd);
        id_bundle.imm             = bus.id_imm;
        id_bundle.shamt           = bus.id_shamt;
        id_bundle.pc4             = bus.id_pc4;
        id_bundle.rdat1           = bus.id_rdat1;
        id_bundle.rdat2           = bus.id_rdat2;
    end

    always_comb begin
        // NOTE: every next-state signal starts from its hold value so no path infers a latch.
        ex_d            = ex_q;
        flush_pending_d = flush_pending_q;
        count_bubble    = 1'b0;
        bubble_cnt_d    = bubble_cnt_q;

        if (!bus.ex_ready) begin
            flush_pending_d = flush_pending_q | bus.flush;
        end else if (halted_q) begin
            ex_d = '0;
        end else if (bus.flush || flush_pending_q) begin
            ex_d            = '0;
            flush_pending_d = 1'b0;
            count_bubble    = 1'b1;
        end else if (hazard) begin
            ex_d         = '0;
            count_bubble = 1'b1;
        end else begin
            ex_d = id_bundle;
        end

        if (count_bubble && !(&bubble_cnt_q)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        // Halt becomes sticky on the same edge that places it in EX.
        halted_d = halted_q | (ex_d.valid & ex_d.ctrl.halt);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_q            <= '0;
            flush_pending_q <= 1'b0;
            halted_q        <= 1'b0;
            bubble_cnt_q    <= '0;
        end else begin
            ex_q            <= ex_d;
            flush_pending_q <= flush_pending_d;
            halted_q        <= halted_d;
            bubble_cnt_q    <= bubble_cnt_d;
        end
    end

    // A taken flush discards the ID instruction, so its hazard need not stall.
    assign bus.id_stall    = ~bus.ex_ready | halted_q | (hazard & ~bus.flush & ~flush_pending_q);

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_rs       = ex_q.rs;
    assign bus.ex_rt       = ex_q.rt;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_wsel     = ex_q.wsel;
    assign bus.ex_aluop    = ex_q.ctrl.aluop;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_shamt    = ex_q.shamt;
    assign bus.ex_MemToReg = ex_q.ctrl.mem_to_reg;
    assign bus.ex_RegWEN   = ex_q.ctrl.reg_wen;
    assign bus.ex_dWEN     = ex_q.ctrl.dwen;
    assign bus.ex_dREN     = ex_q.ctrl.dren;
    assign bus.ex_halt     = ex_q.ctrl.halt;
    assign bus.ex_RegDst   = ex_q.ctrl.reg_dst;
    assign bus.ex_PCSrc    = ex_q.ctrl.pc_src;
    assign bus.ex_ALUSrc   = ex_q.ctrl.alu_src;
    assign bus.ex_pc4      = ex_q.pc4;
    assign bus.ex_rdat1    = ex_q.rdat1;
    assign bus.ex_rdat2    = ex_q.rdat2;
    assign bus.halted      = halted_q;
    assign bus.bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_latch.sv
// Directed-vector bench: the driver queues hand-computed expectations, a
// negedge monitor pops and compares them against the DUT.
module tb_id_ex_hazard_latch;
    import cpu_types_pkg::*;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic       valid;
        regbits_t   rs, rt, rd;
        logic       mtr, rwen, dwen, dren, halt;
        logic [1:0] regdst;
        logic [2:0] alusrc;
    } ins_t;

    typedef struct {
        int          due;
        int          vec;
        bit          is_stall;
        logic [63:0] want;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    ins_t bub, lw5, add, addrt, sw, addi, lw0, use0, jal, ori, hlt;

    id_ex_hazard_latch_if #(.CNT_W(CNT_W)) bus ();

    id_ex_hazard_latch #(.CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [63:0] pack_state(logic v, regbits_t w, word_t pc, logic [4:0] fl,
                                               logic h, logic [CNT_W-1:0] c);
        return 64'({v, w, pc, fl, h, c});
    endfunction

    always @(negedge CLK) begin : monitor
        exp_t        e;
        logic [63:0] got;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.is_stall)
                got = 64'(bus.id_stall);
            else
                got = pack_state(bus.ex_valid, bus.ex_wsel, bus.ex_pc4,
                                 {bus.ex_RegWEN, bus.ex_dWEN, bus.ex_dREN, bus.ex_halt, bus.ex_MemToReg},
                                 bus.halted, bus.bubble_cnt);
            if (e.due < cyc) begin
                n_fail++;
                $display("FAIL stale vec%0d: due cycle %0d, now %0d", e.vec, e.due, cyc);
            end else if (got !== e.want) begin
                n_fail++;
                $display("FAIL %s vec%0d: got %h want %h", e.is_stall ? "id_stall" : "ex_state",
                         e.vec, got, e.want);
            end
        end
    end

    task automatic drive(input ins_t i, input word_t pc, input logic rdy, input logic fl);
        bus.id_valid    = i.valid;
        bus.id_rs       = i.rs;
        bus.id_rt       = i.rt;
        bus.id_rd       = i.rd;
        bus.id_MemToReg = i.mtr;
        bus.id_RegWEN   = i.rwen;
        bus.id_dWEN     = i.dwen;
        bus.id_dREN     = i.dren;
        bus.id_halt     = i.halt;
        bus.id_RegDst   = i.regdst;
        bus.id_ALUSrc   = i.alusrc;
        bus.id_aluop    = ALU_ADD;
        bus.id_imm      = pc[15:0];
        bus.id_shamt    = '0;
        bus.id_PCSrc    = '0;
        bus.id_pc4      = pc;
        bus.id_rdat1    = pc ^ 32'hA5A5_0000;
        bus.id_rdat2    = ~pc;
        bus.ex_ready    = rdy;
        bus.flush       = fl;
    endtask

    // One cycle: stall is checked this cycle, EX state after the next edge.
    task automatic vec(input int n, input ins_t i, input word_t pc, input logic rdy, input logic fl,
                       input logic e_stall, input ins_t e, input regbits_t e_wsel, input word_t e_pc,
                       input logic e_halted, input int e_cnt);
        exp_t x;
        drive(i, pc, rdy, fl);
        x.due = cyc; x.vec = n; x.is_stall = 1'b1; x.want = 64'(e_stall);
        sb.push_back(x);
        x.due = cyc + 1; x.is_stall = 1'b0;
        x.want = pack_state(e.valid, e_wsel, e_pc, {e.rwen, e.dwen, e.dren, e.halt, e.mtr},
                            e_halted, CNT_W'(e_cnt));
        sb.push_back(x);
        @(posedge CLK); #1;
    endtask

    task automatic do_reset(input int n);
        exp_t x;
        @(negedge CLK); #1;
        RST = 1'b1;
        drive(bub, '0, 1'b1, 1'b0);
        x.due = cyc + 1; x.vec = n; x.is_stall = 1'b1; x.want = '0;
        sb.push_back(x);
        x.is_stall = 1'b0;
        sb.push_back(x);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    initial begin
        bub   = '0;
        lw5   = '{valid:1, rs:1, rt:5, rd:0, mtr:1, rwen:1, dwen:0, dren:1, halt:0, regdst:0, alusrc:1};
        add   = '{valid:1, rs:5, rt:2, rd:3, mtr:0, rwen:1, dwen:0, dren:0, halt:0, regdst:1, alusrc:0};
        addrt = '{valid:1, rs:2, rt:5, rd:3, mtr:0, rwen:1, dwen:0, dren:0, halt:0, regdst:1, alusrc:0};
        sw    = '{valid:1, rs:1, rt:5, rd:0, mtr:0, rwen:0, dwen:1, dren:0, halt:0, regdst:0, alusrc:1};
        addi  = '{valid:1, rs:2, rt:5, rd:0, mtr:0, rwen:1, dwen:0, dren:0, halt:0, regdst:0, alusrc:1};
        lw0   = '{valid:1, rs:1, rt:0, rd:0, mtr:1, rwen:1, dwen:0, dren:1, halt:0, regdst:0, alusrc:1};
        use0  = '{valid:1, rs:0, rt:0, rd:4, mtr:0, rwen:1, dwen:0, dren:0, halt:0, regdst:1, alusrc:0};
        jal   = '{valid:1, rs:0, rt:0, rd:0, mtr:0, rwen:1, dwen:0, dren:0, halt:0, regdst:2, alusrc:0};
        ori   = '{valid:1, rs:2, rt:6, rd:7, mtr:0, rwen:1, dwen:0, dren:0, halt:0, regdst:3, alusrc:1};
        hlt   = '{valid:1, rs:0, rt:0, rd:0, mtr:0, rwen:0, dwen:0, dren:0, halt:1, regdst:0, alusrc:0};

        RST = 1'b1;
        drive(bub, '0, 1'b1, 1'b0);
        do_reset(0);

        // Load-use on rs, on store data, and the non-hazard cases.
        vec(1,  lw5,  32'd4,  1, 0,  0, lw5,  5'd5,  32'd4,  0, 0);
        vec(2,  add,  32'd8,  1, 0,  1, bub,  5'd0,  32'd0,  0, 1);
        vec(3,  add,  32'd8,  1, 0,  0, add,  5'd3,  32'd8,  0, 1);
        vec(4,  lw5,  32'd12, 1, 0,  0, lw5,  5'd5,  32'd12, 0, 1);
        vec(5,  sw,   32'd16, 1, 0,  1, bub,  5'd0,  32'd0,  0, 2);
        vec(6,  sw,   32'd16, 1, 0,  0, sw,   5'd5,  32'd16, 0, 2);
        vec(7,  lw5,  32'd20, 1, 0,  0, lw5,  5'd5,  32'd20, 0, 2);
        vec(8,  addi, 32'd24, 1, 0,  0, addi, 5'd5,  32'd24, 0, 2);
        vec(9,  lw0,  32'd28, 1, 0,  0, lw0,  5'd0,  32'd28, 0, 2);
        vec(10, use0, 32'd32, 1, 0,  0, use0, 5'd4,  32'd32, 0, 2);
        // Flush coinciding with a hazard: one bubble, no stall; RegDst=3 resolves to 0.
        vec(11, lw5,  32'd36, 1, 0,  0, lw5,  5'd5,  32'd36, 0, 2);
        vec(12, add,  32'd40, 1, 1,  0, bub,  5'd0,  32'd0,  0, 3);
        vec(13, ori,  32'd44, 1, 0,  0, ori,  5'd0,  32'd44, 0, 3);
        do_reset(14);

        // EX stall for three cycles with a flush in the middle one.
        vec(15, jal,  32'd48, 1, 0,  0, jal,  5'd31, 32'd48, 0, 0);
        vec(16, ori,  32'd52, 0, 0,  1, jal,  5'd31, 32'd48, 0, 0);
        vec(17, ori,  32'd52, 0, 1,  1, jal,  5'd31, 32'd48, 0, 0);
        vec(18, ori,  32'd52, 0, 0,  1, jal,  5'd31, 32'd48, 0, 0);
        vec(19, ori,  32'd52, 1, 0,  0, bub,  5'd0,  32'd0,  0, 1);
        vec(20, ori,  32'd52, 1, 0,  0, ori,  5'd0,  32'd52, 0, 1);

        // Sticky halt, then reset while a flush is pending.
        vec(21, hlt,  32'd56, 1, 0,  0, hlt,  5'd0,  32'd56, 1, 1);
        vec(22, add,  32'd60, 1, 0,  1, bub,  5'd0,  32'd0,  1, 1);
        vec(23, add,  32'd60, 1, 0,  1, bub,  5'd0,  32'd0,  1, 1);
        vec(24, add,  32'd60, 0, 1,  1, bub,  5'd0,  32'd0,  1, 1);
        do_reset(25);

        // 2^CNT_W+3 hazards: counter climbs to 3 and stays there.
        for (int k = 1; k <= 7; k++) begin
            word_t pc;
            ins_t  hz;
            pc = 32'd100 + 32'(k * 8);
            hz = (k % 2 == 1) ? add : addrt;
            vec(100 + 3 * k, lw5, pc,         1, 0, 0, lw5, 5'd5, pc,         0, (k - 1 > 3) ? 3 : k - 1);
            vec(101 + 3 * k, hz,  pc + 32'd4, 1, 0, 1, bub, 5'd0, 32'd0,      0, (k > 3) ? 3 : k);
            vec(102 + 3 * k, hz,  pc + 32'd4, 1, 0, 0, hz,  5'd3, pc + 32'd4, 0, (k > 3) ? 3 : k);
        end

        @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
